// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
//   D             : PC / instruction-address width
//   fetch_state_t : run/halt state encoding
//   LUT_IDX_* / LUT_OFF_* : branch-offset lookup table (index -> signed D-bit offset)
//   sext4()       : sign-extends a 4-bit immediate to D bits
package fetch_pkg;

   localparam int D = 12;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;

   localparam logic [3:0]   LUT_IDX_0  = 4'b0000;
   localparam logic [3:0]   LUT_IDX_13 = 4'b1101;
   localparam logic [3:0]   LUT_IDX_14 = 4'b1110;
   localparam logic [3:0]   LUT_IDX_15 = 4'b1111;

   localparam logic [D-1:0] LUT_OFF_0  = 12'hF9B;   // -101
   localparam logic [D-1:0] LUT_OFF_13 = 12'hF79;   // -135
   localparam logic [D-1:0] LUT_OFF_14 = 12'h00E;   // +14
   localparam logic [D-1:0] LUT_OFF_15 = 12'hF8A;   // -118

   function automatic logic [D-1:0] sext4(input logic [3:0] v);
      return {{(D-4){v[3]}}, v};
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decoder <-> fetch sequencer bundle.
//   master : decoder side, drives start/branch/halt/stall controls, reads PC and status
//   slave  : sequencer side
//   start, start_addr, stall, branch_en, imm_or_lut, pc_ctrl, halt : controls
//   prog_ctr, running, done, cycles                               : registered status
interface fetch_sequencer_if
   import fetch_pkg::*;
#(
   parameter int CW = 16
) ();
   logic          start;
   logic [D-1:0]  start_addr;
   logic          stall;
   logic          branch_en;
   logic          imm_or_lut;
   logic [3:0]    pc_ctrl;
   logic          halt;
   logic [D-1:0]  prog_ctr;
   logic          running;
   logic          done;
   logic [CW-1:0] cycles;

   modport master (
      output start, start_addr, stall, branch_en, imm_or_lut, pc_ctrl, halt,
      input  prog_ctr, running, done, cycles
   );

   modport slave (
      input  start, start_addr, stall, branch_en, imm_or_lut, pc_ctrl, halt,
      output prog_ctr, running, done, cycles
   );
endinterface

// File: rtl/fetch_sequencer_branch_offset_gen.sv
// Combinational branch-offset selection.
//   imm_or_lut_i : 1 selects the lookup table, 0 the sign-extended immediate
//   pc_ctrl_i    : LUT index or 4-bit signed immediate
//   offset_o     : signed D-bit offset
module branch_offset_gen
   import fetch_pkg::*;
(
   input  logic         imm_or_lut_i,
   input  logic [3:0]   pc_ctrl_i,
   output logic [D-1:0] offset_o
);

   always_comb begin
      offset_o = sext4(pc_ctrl_i);
      if (imm_or_lut_i) begin
         unique case (pc_ctrl_i)
            LUT_IDX_0:  offset_o = LUT_OFF_0;
            LUT_IDX_13: offset_o = LUT_OFF_13;
            LUT_IDX_14: offset_o = LUT_OFF_14;
            LUT_IDX_15: offset_o = LUT_OFF_15;
            // Unpopulated entries give a zero offset: the PC spins in place.
            default:    offset_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage program-counter sequencer: owns the PC, a run/halt FSM and a
// saturating RUN-cycle counter.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : fetch_sequencer_if.slave (controls in, PC/status out)
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | fetching; PC advances by 1 or a branch offset each unstalled cycle
// DONE  | halted on the program-end instruction; waits for the next start
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int CW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   fetch_sequencer_if.slave bus
);

   fetch_state_t  state_q;
   logic [D-1:0]  pc_q;
   logic [CW-1:0] cycles_q;
   logic          running_q;
   logic          done_q;

   logic [D-1:0]  offset;
   logic [D-1:0]  step_d;
   logic [D-1:0]  pc_d;

   branch_offset_gen u_offset (
      .imm_or_lut_i (bus.imm_or_lut),
      .pc_ctrl_i    (bus.pc_ctrl),
      .offset_o     (offset)
   );

   // Modular add: wrap-around in either direction is intentional.
   assign step_d = bus.branch_en ? offset : D'(1);
   assign pc_d   = pc_q + step_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         cycles_q  <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_q   <= RUN;
                  pc_q      <= bus.start_addr;
                  cycles_q  <= '0;
                  running_q <= 1'b1;
                  done_q    <= 1'b0;
               end
            end
            RUN: begin
               // Counts stalled cycles and the halt cycle too.
               if (cycles_q != '1) cycles_q <= cycles_q + CW'(1);
               if (bus.halt) begin
                  state_q   <= DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
               end else if (!bus.stall) begin
                  // A stalled branch is dropped; the decoder re-presents it.
                  pc_q <= pc_d;
               end
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.prog_ctr = pc_q;
   assign bus.running  = running_q;
   assign bus.done     = done_q;
   assign bus.cycles   = cycles_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic rst4_n;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   fetch_sequencer_if #(.CW(16)) bus ();
   fetch_sequencer_if #(.CW(4))  bus4 ();

   fetch_sequencer #(.CW(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   fetch_sequencer #(.CW(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst4_n),
      .bus   (bus4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic [11:0] pc, input logic run,
                             input logic dn, input logic [15:0] cyc);
      chk({tag, ".pc"},      32'(bus.prog_ctr), 32'(pc));
      chk({tag, ".running"}, 32'(bus.running),  32'(run));
      chk({tag, ".done"},    32'(bus.done),     32'(dn));
      chk({tag, ".cycles"},  32'(bus.cycles),   32'(cyc));
   endtask

   task automatic ctl(input logic st, input logic hl, input logic br,
                      input logic lut, input logic [3:0] pcc);
      bus.stall      = st;
      bus.halt       = hl;
      bus.branch_en  = br;
      bus.imm_or_lut = lut;
      bus.pc_ctrl    = pcc;
   endtask

   initial begin
      rst_n = 1'b0;
      rst4_n = 1'b0;
      bus.start = 1'b0;
      bus.start_addr = '0;
      ctl(0, 0, 0, 0, 4'h0);
      bus4.start = 1'b0;
      bus4.start_addr = 12'h100;
      bus4.stall = 1'b0;
      bus4.halt = 1'b0;
      bus4.branch_en = 1'b0;
      bus4.imm_or_lut = 1'b0;
      bus4.pc_ctrl = 4'h0;
      step();
      step();
      chk_status("reset", 12'h000, 0, 0, 16'd0);

      // Start at 010 and let it increment five times.
      rst_n = 1'b1;
      rst4_n = 1'b1;
      bus.start = 1'b1;
      bus.start_addr = 12'h010;
      bus4.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus4.start = 1'b0;
      chk_status("start010", 12'h010, 1, 0, 16'd0);
      step(); chk("inc1", 32'(bus.prog_ctr), 32'h011);
      step(); chk("inc2", 32'(bus.prog_ctr), 32'h012);
      step(); chk("inc3", 32'(bus.prog_ctr), 32'h013);
      step(); chk("inc4", 32'(bus.prog_ctr), 32'h014);
      step(); chk_status("inc5", 12'h015, 1, 0, 16'd5);
      chk("cw4_cycles5", 32'(bus4.cycles), 32'd5);

      // start while running is ignored
      bus.start = 1'b1;
      bus.start_addr = 12'h080;
      step();
      bus.start = 1'b0;
      chk_status("start_in_run", 12'h016, 1, 0, 16'd6);

      // halt, then restart at 080
      ctl(0, 1, 0, 0, 4'h0);
      step();
      chk_status("halt1", 12'h016, 0, 1, 16'd7);
      ctl(0, 0, 0, 0, 4'h0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk_status("start080", 12'h080, 1, 0, 16'd0);

      // LUT and immediate branches
      ctl(0, 0, 1, 1, 4'b1110); step(); chk("lut14", 32'(bus.prog_ctr), 32'h08E);
      ctl(0, 0, 1, 0, 4'b1000); step(); chk("imm_m8", 32'(bus.prog_ctr), 32'h086);
      ctl(0, 0, 1, 0, 4'b1010); step(); chk("imm_m6", 32'(bus.prog_ctr), 32'h080);
      ctl(0, 0, 1, 1, 4'b0000); step(); chk("lut0", 32'(bus.prog_ctr), 32'h01B);
      ctl(0, 0, 1, 1, 4'b1101); step(); chk("lut13", 32'(bus.prog_ctr), 32'hF94);
      ctl(0, 0, 1, 1, 4'b1111); step(); chk("lut15", 32'(bus.prog_ctr), 32'hF1E);
      ctl(0, 0, 1, 1, 4'b0101); step(); chk("lut5_spin1", 32'(bus.prog_ctr), 32'hF1E);
      step(); chk_status("lut5_spin2", 12'hF1E, 1, 0, 16'd8);
      ctl(0, 0, 1, 0, 4'b0111); step(); chk("imm_p7", 32'(bus.prog_ctr), 32'hF25);

      // wrap tests from 005
      ctl(0, 1, 0, 0, 4'h0);
      step();
      chk_status("halt2", 12'hF25, 0, 1, 16'd10);
      ctl(0, 0, 0, 0, 4'h0);
      bus.start = 1'b1;
      bus.start_addr = 12'h005;
      step();
      bus.start = 1'b0;
      ctl(0, 0, 1, 0, 4'b1000); step(); chk("wrap_down", 32'(bus.prog_ctr), 32'hFFD);
      ctl(0, 0, 0, 0, 4'h0);
      step();
      step(); chk("pc_fff", 32'(bus.prog_ctr), 32'hFFF);
      step(); chk_status("wrap_up", 12'h000, 1, 0, 16'd4);

      // stall beats branch; halt beats branch
      ctl(1, 0, 1, 0, 4'b0011);
      step(); step(); step();
      chk_status("stall3", 12'h000, 1, 0, 16'd7);
      ctl(0, 1, 1, 0, 4'b0011);
      step();
      chk_status("halt_br", 12'h000, 0, 1, 16'd8);
      ctl(1, 1, 1, 0, 4'b0011);
      step(); step();
      ctl(0, 0, 1, 0, 4'b0011);
      step();
      chk_status("done_hold", 12'h000, 0, 1, 16'd8);

      // restart at 200
      ctl(0, 0, 0, 0, 4'h0);
      bus.start = 1'b1;
      bus.start_addr = 12'h200;
      step();
      bus.start = 1'b0;
      chk_status("start200", 12'h200, 1, 0, 16'd0);

      // reset mid-RUN at 123, with start and branch also asserted
      ctl(0, 1, 0, 0, 4'h0);
      step();
      ctl(0, 0, 0, 0, 4'h0);
      bus.start = 1'b1;
      bus.start_addr = 12'h123;
      step();
      bus.start = 1'b0;
      chk_status("start123", 12'h123, 1, 0, 16'd0);
      step();
      rst_n = 1'b0;
      bus.start = 1'b1;
      ctl(0, 0, 1, 0, 4'b0111);
      step();
      chk_status("rst_mid_run", 12'h000, 0, 0, 16'd0);
      rst_n = 1'b1;
      bus.start = 1'b0;
      ctl(0, 0, 0, 0, 4'h0);
      step();
      chk_status("idle_after_rst", 12'h000, 0, 0, 16'd0);

      // CW=4 instance has been running throughout: saturated at 15
      chk("cw4_sat", 32'(bus4.cycles), 32'd15);
      chk("cw4_running", 32'(bus4.running), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
